// File: rtl/updown_mod_counter_if.sv
// Bus bundle for updown_mod_counter: control inputs and counter status outputs.
// The master drives the controls; the counter sits on the slave side.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             up_down;
  logic             sat_mode;
  logic             evt_clr;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             borrow;
  logic             at_max;
  logic             at_min;
  logic             load_err;
  logic [EVT_W-1:0] wrap_evts;

  modport master (
    output enable, load, din, up_down, sat_mode, evt_clr,
    input  count, carry, borrow, at_max, at_min, load_err, wrap_evts
  );

  modport slave (
    input  enable, load, din, up_down, sat_mode, evt_clr,
    output count, carry, borrow, at_max, at_min, load_err, wrap_evts
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Programmable-range up/down counter with wrap/saturate mode, registered
// carry/borrow pulses for cascading, clamped loads and a wrap-event counter.
module updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 11,
  parameter int EVT_W   = 8
) (
  input  logic clock,
  input  logic reset,
  updown_mod_counter_if.slave bus
);

  // Reject impossible ranges at elaboration time.
  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_range
    $error("updown_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [EVT_W-1:0] EVT_SAT = '1;

  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic             borrow_q;
  logic             load_err_q;
  logic [EVT_W-1:0] evts_q;
  logic             wrap_up;
  logic             wrap_dn;

  // Wrap conditions for this edge; a load always suppresses the step.
  always_comb begin
    wrap_up = !bus.load && bus.enable && !bus.up_down && !bus.sat_mode &&
              (count_q == MAX_V);
    wrap_dn = !bus.load && bus.enable &&  bus.up_down && !bus.sat_mode &&
              (count_q == MIN_V);
  end

  // Count register and single-cycle pulses: reset > load > step > hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= MIN_V;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (bus.din > MAX_V) begin
          count_q    <= MAX_V;
          load_err_q <= 1'b1;
        end else if (bus.din < MIN_V) begin
          count_q    <= MIN_V;
          load_err_q <= 1'b1;
        end else begin
          count_q <= bus.din;
        end
      end else if (bus.enable) begin
        if (wrap_up) begin
          count_q <= MIN_V;
          carry_q <= 1'b1;
        end else if (wrap_dn) begin
          count_q  <= MAX_V;
          borrow_q <= 1'b1;
        end else if (!bus.up_down && count_q != MAX_V) begin
          count_q <= count_q + 1'b1;
        end else if (bus.up_down && count_q != MIN_V) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  // Saturating wrap-event counter; clear beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || bus.evt_clr) begin
      evts_q <= '0;
    end else if ((wrap_up || wrap_dn) && evts_q != EVT_SAT) begin
      evts_q <= evts_q + 1'b1;
    end
  end

  assign bus.count     = count_q;
  assign bus.carry     = carry_q;
  assign bus.borrow    = borrow_q;
  assign bus.load_err  = load_err_q;
  assign bus.wrap_evts = evts_q;
  assign bus.at_max    = (count_q == MAX_V);
  assign bus.at_min    = (count_q == MIN_V);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two builds (default 0..11/EVT_W=8 and
// 3..12/EVT_W=2) share one stimulus stream and are compared every cycle
// against an integer reference model, plus directed scenario checks.
module tb_updown_mod_counter;

  logic clock = 1'b0;
  logic reset;
  logic en, ld, ud, sat, clr;
  logic [3:0] din;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = default build, 1 = narrow build.
  int minv[2], maxv[2], evmax[2];
  int m_cnt[2], m_evt[2];
  bit m_c[2], m_b[2], m_le[2];

  updown_mod_counter_if #(.WIDTH(4), .EVT_W(8)) bus0 ();
  updown_mod_counter_if #(.WIDTH(4), .EVT_W(2)) bus1 ();

  assign bus0.enable = en;  assign bus1.enable = en;
  assign bus0.load = ld;    assign bus1.load = ld;
  assign bus0.din = din;    assign bus1.din = din;
  assign bus0.up_down = ud; assign bus1.up_down = ud;
  assign bus0.sat_mode = sat; assign bus1.sat_mode = sat;
  assign bus0.evt_clr = clr;  assign bus1.evt_clr = clr;

  updown_mod_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(11), .EVT_W(8)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  updown_mod_counter #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(12), .EVT_W(2)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Next-state of the reference model, straight from the counting rules.
  task automatic model_step(input int k);
    m_c[k] = 0; m_b[k] = 0; m_le[k] = 0;
    if (reset) begin
      m_cnt[k] = minv[k];
      m_evt[k] = 0;
      return;
    end
    if (ld) begin
      if (int'(din) > maxv[k])      begin m_cnt[k] = maxv[k]; m_le[k] = 1; end
      else if (int'(din) < minv[k]) begin m_cnt[k] = minv[k]; m_le[k] = 1; end
      else m_cnt[k] = int'(din);
    end else if (en) begin
      if (!ud) begin
        if (m_cnt[k] < maxv[k]) m_cnt[k] = m_cnt[k] + 1;
        else if (!sat) begin m_cnt[k] = minv[k]; m_c[k] = 1; end
      end else begin
        if (m_cnt[k] > minv[k]) m_cnt[k] = m_cnt[k] - 1;
        else if (!sat) begin m_cnt[k] = maxv[k]; m_b[k] = 1; end
      end
    end
    if (clr) m_evt[k] = 0;
    else if ((m_c[k] || m_b[k]) && m_evt[k] < evmax[k]) m_evt[k] = m_evt[k] + 1;
  endtask

  task automatic compare_all();
    chk("d0.count",    32'(bus0.count),     32'(m_cnt[0]));
    chk("d0.carry",    32'(bus0.carry),     32'(m_c[0]));
    chk("d0.borrow",   32'(bus0.borrow),    32'(m_b[0]));
    chk("d0.load_err", 32'(bus0.load_err),  32'(m_le[0]));
    chk("d0.at_max",   32'(bus0.at_max),    32'(m_cnt[0] == maxv[0]));
    chk("d0.at_min",   32'(bus0.at_min),    32'(m_cnt[0] == minv[0]));
    chk("d0.evts",     32'(bus0.wrap_evts), 32'(m_evt[0]));
    chk("d1.count",    32'(bus1.count),     32'(m_cnt[1]));
    chk("d1.carry",    32'(bus1.carry),     32'(m_c[1]));
    chk("d1.borrow",   32'(bus1.borrow),    32'(m_b[1]));
    chk("d1.load_err", 32'(bus1.load_err),  32'(m_le[1]));
    chk("d1.at_max",   32'(bus1.at_max),    32'(m_cnt[1] == maxv[1]));
    chk("d1.at_min",   32'(bus1.at_min),    32'(m_cnt[1] == minv[1]));
    chk("d1.evts",     32'(bus1.wrap_evts), 32'(m_evt[1]));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, check outputs.
  task automatic apply(input bit r, input bit e, input bit l, input int d,
                       input bit u, input bit s, input bit c);
    reset = r; en = e; ld = l; din = 4'(d); ud = u; sat = s; clr = c;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    minv[0] = 0; maxv[0] = 11; evmax[0] = 255;
    minv[1] = 3; maxv[1] = 12; evmax[1] = 3;
    reset = 1'b1; en = 0; ld = 0; din = '0; ud = 0; sat = 0; clr = 0;
    #2;

    // Reset state.
    apply(1, 0, 0, 0, 0, 0, 0);
    chk("rst.count", 32'(bus0.count), 32'd0);
    chk("rst.count1", 32'(bus1.count), 32'd3);

    // Count up through the wrap: 1..11 then 0 with carry.
    for (int i = 0; i < 12; i++) apply(0, 1, 0, 0, 0, 0, 0);
    chk("up.wrap_count", 32'(bus0.count), 32'd0);
    chk("up.carry", 32'(bus0.carry), 32'd1);
    chk("up.evts", 32'(bus0.wrap_evts), 32'd1);

    // Down-wrap from MIN, then a normal down step.
    apply(0, 1, 0, 0, 1, 0, 0);
    chk("dn.wrap_count", 32'(bus0.count), 32'd11);
    chk("dn.borrow", 32'(bus0.borrow), 32'd1);
    chk("dn.evts", 32'(bus0.wrap_evts), 32'd2);
    apply(0, 1, 0, 0, 1, 0, 0);
    chk("dn.step", 32'(bus0.count), 32'd10);
    chk("dn.borrow_clr", 32'(bus0.borrow), 32'd0);

    // Saturate at both ends.
    apply(0, 0, 1, 11, 0, 1, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 1, 0);
    chk("sat.max", 32'(bus0.count), 32'd11);
    chk("sat.no_carry", 32'(bus0.carry), 32'd0);
    chk("sat.at_max", 32'(bus0.at_max), 32'd1);
    apply(0, 0, 1, 0, 0, 1, 0);
    chk("ld.below_min_err", 32'(bus1.load_err), 32'd1);
    apply(0, 1, 0, 0, 1, 1, 0);
    chk("sat.min", 32'(bus0.count), 32'd0);
    chk("sat.at_min", 32'(bus0.at_min), 32'd1);

    // Clamped load, then load beating enable.
    apply(0, 0, 1, 14, 0, 0, 0);
    chk("ld.clamp", 32'(bus0.count), 32'd11);
    chk("ld.err", 32'(bus0.load_err), 32'd1);
    apply(0, 1, 1, 5, 0, 0, 0);
    chk("ld.wins", 32'(bus0.count), 32'd5);
    chk("ld.err_clr", 32'(bus0.load_err), 32'd0);
    chk("ld.no_carry", 32'(bus0.carry), 32'd0);

    // Reset beats load and step mid-run.
    apply(0, 0, 1, 7, 0, 0, 0);
    apply(1, 1, 1, 3, 0, 0, 0);
    chk("rst.mid_count", 32'(bus0.count), 32'd0);
    chk("rst.mid_pulses", 32'({bus0.carry, bus0.borrow, bus0.load_err}), 32'd0);

    // Narrow build: five wraps saturate the 2-bit event counter.
    for (int i = 0; i < 50; i++) apply(0, 1, 0, 0, 0, 0, 0);
    chk("evt.sat", 32'(bus1.wrap_evts), 32'd3);
    for (int i = 0; i < 9; i++) apply(0, 1, 0, 0, 0, 0, 0);
    chk("evt.pre_wrap", 32'(bus1.count), 32'd12);
    apply(0, 1, 0, 0, 0, 0, 1);
    chk("evt.clr_wins_carry", 32'(bus1.carry), 32'd1);
    chk("evt.clr_wins", 32'(bus1.wrap_evts), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 59) == 0, ($urandom % 4) != 0,
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
            ($urandom % 3) == 0, ($urandom % 4) == 0,
            $urandom_range(0, 39) == 0);
      if (bus0.carry && bus0.borrow) chk("inv.carry_borrow", 32'd1, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
